// File: rtl/decoder_index_pkg.sv
// decoder_index_pkg: issue FSM encoding, default sizing
// and the occupancy-width helper for the index issuer.
package decoder_index_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    GAP
  } state_e;

  localparam int DEF_IDX_W = 10;
  localparam int DEF_DEPTH = 8;
  localparam int DEF_HOLD  = 1;

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/decoder_index_fifo.sv
// decoder_index_fifo: pointer/count FIFO holding indices
// waiting to be issued; flush clears it synchronously.
module decoder_index_fifo
  import decoder_index_pkg::*;
#(
  parameter int IDX_W = DEF_IDX_W,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      push,
  input  logic                      pop,
  input  logic [IDX_W-1:0]          wdata,
  output logic [IDX_W-1:0]          head,
  output logic [cnt_w(DEPTH)-1:0]   count,
  output logic                      full,
  output logic                      empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [IDX_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = count == CW'(DEPTH);
  assign empty   = count == '0;
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)
        count <= count + CW'(1);
      else if (!do_push && do_pop)
        count <= count - CW'(1);
    end
  end

  // Storage needs no reset; only slots below count are read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/decoder_index_issuer.sv
// decoder_index_issuer: buffers indices and issues them to the
// one-hot decoder with a break-before-make gap. Option: DECODER_INDEX_DEDUP_EN.
module decoder_index_issuer
  import decoder_index_pkg::*;
#(
  parameter int IDX_W = DEF_IDX_W,
  parameter int DEPTH = DEF_DEPTH,
  parameter int HOLD  = DEF_HOLD
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [IDX_W-1:0]         in_index,
  output logic [IDX_W-1:0]         dec_binary_out,
  output logic                     dec_enable,
  output logic                     busy,
  output logic [cnt_w(DEPTH)-1:0]  count
`ifdef DECODER_INDEX_DEDUP_EN
  ,
  output logic                     dedup_drop
`endif
);

  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

  state_e           state;
  state_e           state_d;
  logic [HW-1:0]    hold_cnt;
  logic [HW-1:0]    hold_d;
  logic             en_d;
  logic             pop;
  logic             load;
  logic             match;
  logic             full;
  logic             empty;
  logic [IDX_W-1:0] head;

  assign in_ready = !reset && !flush && !full;
  assign busy     = !empty || (state != IDLE);

  decoder_index_fifo #(
    .IDX_W (IDX_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .push  (in_valid && in_ready),
    .pop   (pop),
    .wdata (in_index),
    .head  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

`ifdef DECODER_INDEX_DEDUP_EN
  logic [IDX_W-1:0] last_idx;
  logic             last_vld;

  assign match = last_vld && (head == last_idx);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_idx   <= '0;
      last_vld   <= 1'b0;
      dedup_drop <= 1'b0;
    end else if (flush) begin
      last_vld   <= 1'b0;
      dedup_drop <= 1'b0;
    end else begin
      dedup_drop <= pop && !load;
      if (load) begin
        last_idx <= head;
        last_vld <= 1'b1;
      end
    end
  end
`else
  assign match = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      hold_cnt       <= '0;
      dec_enable     <= 1'b0;
      dec_binary_out <= '0;
    end else begin
      state      <= state_d;
      hold_cnt   <= hold_d;
      dec_enable <= en_d;
      if (load) dec_binary_out <= head;
    end
  end

  // IDLE and GAP share the pop path; a duplicate pops without issuing.
  always_comb begin
    state_d = state;
    hold_d  = hold_cnt;
    en_d    = dec_enable;
    pop     = 1'b0;
    load    = 1'b0;
    if (flush) begin
      state_d = IDLE;
      hold_d  = '0;
      en_d    = 1'b0;
    end else begin
      case (state)
        ISSUE: begin
          if (hold_cnt != '0) begin
            hold_d = hold_cnt - HW'(1);
          end else begin
            en_d    = 1'b0;
            state_d = GAP;
          end
        end
        default: begin
          en_d    = 1'b0;
          state_d = IDLE;
          if (!empty) begin
            pop = 1'b1;
            if (!match) begin
              load    = 1'b1;
              en_d    = 1'b1;
              hold_d  = HW'(HOLD - 1);
              state_d = ISSUE;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_decoder_index_issuer.sv
// tb_decoder_index_issuer: randomized producer against a
// timestamp/queue reference model of the issuer.
module tb_decoder_index_issuer;

  localparam int IDX_W = 10;
  localparam int DEPTH = 8;
  localparam int HOLD  = 2;
`ifdef DECODER_INDEX_DEDUP_EN
  localparam bit DEDUP = 1'b1;
`else
  localparam bit DEDUP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [IDX_W-1:0] in_index;
  logic [IDX_W-1:0] dec_binary_out;
  logic             dec_enable;
  logic             busy;
  logic [3:0]       count;
`ifdef DECODER_INDEX_DEDUP_EN
  logic             dedup_drop;
`endif

  always #5 clk = ~clk;

  decoder_index_issuer #(
    .IDX_W (IDX_W),
    .DEPTH (DEPTH),
    .HOLD  (HOLD)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_index       (in_index),
    .dec_binary_out (dec_binary_out),
    .dec_enable     (dec_enable),
    .busy           (busy),
    .count          (count)
`ifdef DECODER_INDEX_DEDUP_EN
    ,
    .dedup_drop     (dedup_drop)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag,
                     input longint got,
                     input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d exp=%0d t=%0t",
               tag, got, exp, $time);
    end
  endtask

  // Model: queue of waiting indices plus timestamps.
  // An index popped at edge e keeps enable high after edges
  // e..e+HOLD-1; the next pop may happen at edge e+HOLD+1.
  int q[$];
  int m_out   = 0;
  int en_end  = 0;
  int free_at = 0;
  int edge_n  = 0;
  bit last_v  = 1'b0;
  int last_i  = 0;
  bit m_drop  = 1'b0;

  bit pv = 1'b0;
  int pi = 0;

  task automatic model_reset();
    q.delete();
    m_out   = 0;
    en_end  = 0;
    free_at = 0;
    last_v  = 1'b0;
    m_drop  = 1'b0;
    pv      = 1'b0;
  endtask

  task automatic model_edge(input bit v, input int idx,
                            input bit fl, input bit rdy);
    int h;
    edge_n++;
    m_drop = 1'b0;
    if (fl) begin
      q.delete();
      en_end  = 0;
      free_at = 0;
      last_v  = 1'b0;
    end else begin
      if (q.size() > 0 && edge_n >= free_at) begin
        h = q.pop_front();
        if (DEDUP && last_v && h == last_i) begin
          m_drop  = 1'b1;
          free_at = edge_n;
        end else begin
          m_out   = h;
          en_end  = edge_n + HOLD;
          free_at = edge_n + HOLD + 1;
          last_v  = 1'b1;
          last_i  = h;
        end
      end
      if (v && rdy) q.push_back(idx);
    end
  endtask

  task automatic check_outputs();
    chk("dec_enable", dec_enable, edge_n < en_end);
    chk("dec_binary_out", dec_binary_out, m_out);
    chk("count", count, q.size());
    chk("busy", busy,
        (q.size() != 0) || (edge_n < free_at));
`ifdef DECODER_INDEX_DEDUP_EN
    chk("dedup_drop", dedup_drop, m_drop);
`endif
  endtask

  task automatic step(input bit v, input int idx,
                      input bit fl, output bit acc);
    bit rdy;
    @(negedge clk);
    check_outputs();
    in_valid = v;
    in_index = IDX_W'(idx);
    flush    = fl;
    rdy      = !fl && (q.size() < DEPTH);
    #1 chk("in_ready", in_ready, rdy);
    acc = v && rdy;
    @(posedge clk);
    model_edge(v, idx, fl, rdy);
  endtask

  task automatic push1(input int idx);
    bit a;
    step(1'b1, idx, 1'b0, a);
  endtask

  task automatic idle(input int n);
    bit a;
    repeat (n) step(1'b0, $urandom_range(0, 1023), 1'b0, a);
  endtask

  // Producer keeps an offered index until it is accepted.
  task automatic produce(input int n, input int vprob,
                         input int fprob, input int maxi);
    bit fl;
    bit a;
    repeat (n) begin
      fl = $urandom_range(0, 99) < fprob;
      if (!pv && $urandom_range(0, 99) < vprob) begin
        pv = 1'b1;
        pi = $urandom_range(0, maxi);
      end
      step(pv, pv ? pi : $urandom_range(0, 1023), fl, a);
      if (a) pv = 1'b0;
    end
  endtask

  task automatic async_reset_mid();
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rst_enable", dec_enable, 0);
    chk("rst_count", count, 0);
    chk("rst_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_binary", dec_binary_out, 0);
    #1 reset = 1'b0;
    model_reset();
  endtask

  initial begin
    bit a;
    reset    = 1'b1;
    flush    = 1'b0;
    in_valid = 1'b0;
    in_index = '0;
    #12;
    chk("por_ready", in_ready, 0);
    chk("por_count", count, 0);
    chk("por_enable", dec_enable, 0);
    @(negedge clk);
    reset = 1'b0;

    push1(5);
    idle(6);

    push1(1);
    push1(2);
    push1(3);
    idle(12);

    produce(20, 100, 0, 1023);
    idle(4);

    produce(6, 100, 0, 1023);
    step(1'b1, 77, 1'b1, a);
    idle(3);

    produce(7, 100, 0, 1023);
    async_reset_mid();
    push1(0);
    idle(6);

    push1(7);
    push1(7);
    push1(9);
    idle(12);

    produce(1500, 60, 3, 15);
    produce(1500, 40, 1, 1023);
    repeat (4) begin
      produce(40, 90, 0, 7);
      async_reset_mid();
    end
    idle(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
